// File: rtl/weight_fetch.sv
// weight_fetch: streams a contiguous range of 16-bit weights out of the weight
// SRAM into a small FIFO that feeds the downstream consumer.
// Optional feature: define WEIGHT_FETCH_PERF_EN to build the downstream stall
// counter; otherwise stall_cnt is tied to zero.
// The SRAM requester port is flattened into mem_* signals
// (cs, oe, w_req, addr, w_data, r_data).
module weight_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 196608
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [17:0] length,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [15:0] w_data,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_w_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data,
  output logic [31:0] stall_cnt
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [18:0] MEM_LIMIT = 19'(MEM_WORDS);
  localparam logic [CW:0] DEPTH_W   = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t          state_q, state_d;
  logic [17:0]     addr_q, remain_q;
  logic            inflight_q;
  logic            err_q;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [18:0]     end_addr;
  logic            in_range, accept, reject, issue, fifo_wr, fifo_rd;
  logic [CW:0]     occupancy;
  logic            unused_rdata;

  // Upper half of each SRAM word carries no weight data.
  assign unused_rdata = ^mem_r_data[31:16];

  // Range check uses a 19-bit sum so a burst can never wrap past the top.
  assign end_addr  = {1'b0, base_addr} + {1'b0, length};
  assign in_range  = end_addr <= MEM_LIMIT;
  assign accept    = start && (state_q == IDLE) && (length != '0) && in_range;
  assign reject    = start && (state_q == IDLE) && (length != '0) && !in_range;

  // Credit check counts only registered state, so w_ready never reaches mem_cs.
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue     = (state_q == FETCH) && (occupancy < DEPTH_W);
  assign fifo_wr   = inflight_q;
  assign fifo_rd   = (count_q != '0) && w_ready;

  assign mem_cs     = issue;
  assign mem_oe     = (state_q == FETCH) || (state_q == DRAIN);
  assign mem_w_req  = 1'b1;
  assign mem_addr   = {14'd0, addr_q};
  assign mem_w_data = '0;
  assign busy       = (state_q == FETCH) || (state_q == DRAIN);
  assign done       = (state_q == FIN);
  assign err        = err_q;
  assign w_valid    = (count_q != '0);
  assign w_data     = fifo_mem[rd_ptr];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; zero-length starts complete without touching the SRAM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && length == '0) state_d = FIN;
        else if (accept)           state_d = FETCH;
      end
      FETCH: if (issue && remain_q == 18'd1) state_d = DRAIN;
      DRAIN: if (count_q == '0 && !inflight_q) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst address/remaining count, one-deep in-flight tracker and err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= reject;
      inflight_q <= issue;
      if (accept) begin
        addr_q   <= base_addr;
        remain_q <= length;
      end else if (issue) begin
        addr_q   <= addr_q + 18'd1;
        remain_q <= remain_q - 18'd1;
      end
    end
  end

  // Output FIFO: returned read data is written one cycle after its issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= mem_r_data[15:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef WEIGHT_FETCH_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of busy cycles where the consumer holds off valid data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       stall_q <= '0;
    else if (accept)                               stall_q <= '0;
    else if (busy && w_valid && !w_ready && stall_q != 32'hFFFF_FFFF)
                                                   stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/weight_fetch.md
WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
REQ-002 Parameter: MEM_WORDS, 196608, addressable weight words (6 x 32768).
REQ-003 Port: clk  input  1  single clock; all state on posedge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to begin a fetch burst; honoured only in IDLE.
REQ-006 Port: base_addr  input  18  first word address; sampled on accepted start.
REQ-007 Port: length  input  18  word count; sampled on accepted start.
REQ-008 Port: busy  output  1  high from the cycle after an accepted start until done/err.
REQ-009 Port: done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-010 Port: err  output  1  one-cycle pulse on a rejected (out-of-range) start.
REQ-011 Port: w_valid  output  1  FIFO head valid.
REQ-012 Port: w_ready  input  1  downstream accepts the head when w_valid && w_ready.
REQ-013 Port: w_data  output  16  weight word at the FIFO head.
REQ-014 Port: mem  SinglePortRamIntf.compute  -  requester side of the weight SRAM (cs, oe, W_req, addr, W_data, R_data).
REQ-015 Port: stall_cnt  output  32  downstream stall cycle count (see Configuration).

Function
REQ-016 FSM states: IDLE, FETCH, DRAIN, FIN; reset state IDLE.
REQ-017 IDLE -> FETCH on start when length != 0 and base_addr + length <= MEM_WORDS (19-bit sum, no wrap).
REQ-018 IDLE -> FIN on start with length == 0; no SRAM access; done pulses in the following cycle.
REQ-019 IDLE stays IDLE on start with base_addr + length > MEM_WORDS; err pulses the next cycle; no SRAM access.
REQ-020 start while not IDLE is ignored; sampled base_addr/length are unaffected.
REQ-021 Read issue in FETCH: cs=1, W_req=1 (read), addr = current address zero-extended, W_data = 0; only when fifo_count + inflight < FIFO_DEPTH.
REQ-022 Read latency exactly 1 cycle: R_data[15:0] of cycle N+1 is written to the FIFO for an issue in cycle N; R_data[31:16] ignored.
REQ-023 oe is 1 in every FETCH and DRAIN cycle, so oe is held through each data-return cycle; oe=0 in IDLE and FIN.
REQ-024 cs=0 in every non-issue cycle; W_req never 0 (block never writes).
REQ-025 Address increments by 1 per issue; FETCH -> DRAIN after the length-th issue.
REQ-026 DRAIN -> FIN when FIFO empty and no read in flight; FIN -> IDLE after one cycle with done=1.
REQ-027 FIFO: w_data/w_valid driven from registered head; no combinational path from w_ready to mem.cs within the same cycle beyond the credit check.
REQ-028 Simultaneous FIFO write and pop when full-minus-in-flight: both occur, count unchanged; FIFO never overflows, never drops or duplicates data, order preserved.
REQ-029 w_valid may stay high with w_ready low indefinitely; w_data stable while stalled.

Reset
REQ-030 rst asserted: state IDLE, busy=0, done=0, err=0, w_valid=0, w_data=0, cs=0, oe=0, W_req=1, addr=0, FIFO empty, inflight=0, stall_cnt=0.
REQ-031 rst mid-burst aborts immediately; in-flight read data arriving after rst deassert is discarded; no done pulse.

Configuration
REQ-032 Macro WEIGHT_FETCH_PERF_EN defined: stall_cnt increments on each busy cycle with w_valid=1 and w_ready=0, saturates at 0xFFFFFFFF, clears on accepted start.
REQ-033 Macro undefined: stall_cnt port present, tied to 0; no counter logic.

Verification
REQ-034 base_addr=0, length=8, w_ready=1, SRAM word i = i+1 -> w_data 1..8 in order, first w_valid 2 cycles after FETCH entry, one done pulse, busy low after.
REQ-035 base_addr=0x7FFE, length=4, w_ready=1 -> reads cross bank 0/1 boundary at 0x8000; data at 0x7FFE..0x8001 delivered correctly.
REQ-036 length=8, w_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH reads issued before stall, no overflow, all 8 words delivered; with WEIGHT_FETCH_PERF_EN stall_cnt = 20 (minus cycles before first w_valid).
REQ-037 base_addr=0x2FFFF, length=2 -> err pulse, no cs asserted, busy stays 0; length=0 -> done pulse, no cs.
REQ-038 rst asserted mid-burst after 3 words delivered -> all outputs at reset values; new start base_addr=0x100, length=2 delivers only words 0x100, 0x101.
